// File: rtl/tx_handshake.sv
// tx_handshake: transmit-side handshake between the router core and the TX unit.
//
// The core pushes packets into a small circular FIFO with single-cycle pushes.
// Each packet is offered to the TX unit with a four-phase Valid/Ready
// handshake: wait for Ready high, raise Valid, TX drops Ready to accept,
// drop Valid, then wait for Ready to return.
// A packet that is not accepted within TIMEOUT cycles is discarded and
// flagged on tx_err.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   rc_pkt_valid   core pushes rc_pkt_data this cycle
//   rc_pkt_data    packet from core (DATA_W bits)
//   tx_rdy         FIFO not full; core may push
//   tx_sent        one-cycle pulse per packet accepted by TX
//   tx_ovf         sticky; a push arrived while the FIFO was full
//   tx_err         sticky; a packet was aborted by timeout
//   TX_Data_Ready  TX unit ready; TX drops it to accept
//   TX_Data_Valid  packet on TX_Data is valid
//   TX_Data        packet to TX unit (DATA_W bits)
module tx_handshake #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rc_pkt_valid,
   input  logic [DATA_W-1:0] rc_pkt_data,
   output logic              tx_rdy,
   output logic              tx_sent,
   output logic              tx_ovf,
   output logic              tx_err,
   input  logic              TX_Data_Ready,
   output logic              TX_Data_Valid,
   output logic [DATA_W-1:0] TX_Data
);

   localparam int                PTR_W      = $clog2(DEPTH);
   localparam int                CNT_W      = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(DEPTH - 1);
   localparam logic [15:0]       TIMER_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_RST     = 2'd0,
      ST_IDLE    = 2'd1,
      ST_SEND    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t              state_r;
   logic [DATA_W-1:0]   mem_r [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [CNT_W-1:0]    count_r;
   logic [15:0]         timer_r;
   logic                pop_s;
   logic                full_s;
   logic                push_ok_s;

   // Circular pointer advance; DEPTH is a power of two but the wrap is explicit.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_LAST) begin
         return {PTR_W{1'b0}};
      end else begin
         return ptr + PTR_W'(1);
      end
   endfunction

   // The head leaves the FIFO when SEND ends, either by acceptance or by timeout.
   // The Ready test comes first, so acceptance wins over a coinciding timeout.
   always_comb begin
      pop_s = 1'b0;
      if (state_r == ST_SEND) begin
         if (!TX_Data_Ready) begin
            pop_s = 1'b1;
         end else if (timer_r == TIMER_LAST) begin
            pop_s = 1'b1;
         end else begin
            pop_s = 1'b0;
         end
      end else begin
         pop_s = 1'b0;
      end
   end

   // A push into a full FIFO still fits when a pop frees a slot in the same cycle.
   assign full_s    = (count_r == FULL_CNT);
   assign push_ok_s = rc_pkt_valid && (!full_s || pop_s);
   assign tx_rdy    = !full_s;

   // FIFO storage, pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         tx_ovf   <= 1'b0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= rc_pkt_data;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_ok_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
         if (rc_pkt_valid && !push_ok_s) begin
            tx_ovf <= 1'b1;
         end
      end
   end

   // Handshake state machine; every output is registered alongside the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_RST;
         timer_r       <= 16'd0;
         TX_Data_Valid <= 1'b0;
         TX_Data       <= {DATA_W{1'b0}};
         tx_sent       <= 1'b0;
         tx_err        <= 1'b0;
      end else begin
         tx_sent <= 1'b0;
         case (state_r)
            ST_RST: begin
               TX_Data_Valid <= 1'b0;
               if (TX_Data_Ready) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_RST;
               end
            end
            ST_IDLE: begin
               if ((count_r != {CNT_W{1'b0}}) && TX_Data_Ready) begin
                  TX_Data       <= mem_r[rd_ptr_r];
                  timer_r       <= 16'd0;
                  TX_Data_Valid <= 1'b1;
                  state_r       <= ST_SEND;
               end else begin
                  TX_Data_Valid <= 1'b0;
                  state_r       <= ST_IDLE;
               end
            end
            ST_SEND: begin
               if (!TX_Data_Ready) begin
                  tx_sent       <= 1'b1;
                  TX_Data_Valid <= 1'b0;
                  state_r       <= ST_RELEASE;
               end else if (timer_r == TIMER_LAST) begin
                  // Abort: the packet is dropped and the TX unit must re-arm via RST.
                  tx_err        <= 1'b1;
                  TX_Data_Valid <= 1'b0;
                  state_r       <= ST_RST;
               end else begin
                  timer_r       <= timer_r + 16'd1;
                  TX_Data_Valid <= 1'b1;
                  state_r       <= ST_SEND;
               end
            end
            ST_RELEASE: begin
               TX_Data_Valid <= 1'b0;
               if (TX_Data_Ready) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_RELEASE;
               end
            end
            default: begin
               TX_Data_Valid <= 1'b0;
               state_r       <= ST_RST;
            end
         endcase
      end
   end

endmodule
